fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch and program-counter block that sits on the opposite side of the pc_control interface from control_unit.
- It drives the 32-bit instruction into control_unit, which decodes it and returns pc_control. The block then uses pc_control to compute the next PC.
- It fetches from instruction memory through a request/acknowledge handshake, with one instruction in flight at a time.
- A stall input holds the current instruction at issue.

Parameters:
RESET_VECTOR  32'h0000_0000  PC loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
stall  input  1  1 = hold the current instruction in ISSUE.
pc_control  input  4  next-PC select from control_unit; sampled only at issue.
jr_target  input  32  register rs data, used for jump register.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch word address (byte address, bits [1:0]=0).
imem_ack  input  1  memory acknowledge; imem_rdata is valid in the same cycle.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  registered instruction to control_unit.
instr_valid  output  1  instruction holds a valid fetched word.
pc  output  32  address of the current instruction.
pc_plus4  output  32  pc + 4, combinational.
misaligned_err  output  1  sticky flag: misaligned target, block halted.

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - pc = RESET_VECTOR; instruction = 32'h0000_0000 (NOP); instr_valid = 0.
  - imem_req = 0; misaligned_err = 0; state = S_BOOT.
- States:
  - S_BOOT: one cycle after reset is released, then go to S_FETCH with imem_req = 1.
  - S_FETCH:
    - imem_req = 1; imem_addr = pc; both stable until imem_ack.
    - On imem_ack: instruction <= imem_rdata, instr_valid <= 1, imem_req <= 0, go to S_ISSUE.
    - stall is ignored in this state.
  - S_ISSUE:
    - instruction and pc are held; control_unit resolves pc_control combinationally.
    - stall=1: hold everything.
    - stall=0: pc <= next_pc, instr_valid <= 0, imem_req <= 1, go to S_FETCH.
  - S_HALT: imem_req = 0, instr_valid = 0, misaligned_err = 1. Exit only through reset.
- next_pc, all additions modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 is silent):
  - 4'b0001 (jump): {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - 4'b0010 (jump register): jr_target.
  - 4'b0011 (branch taken): pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}.
  - Every other value, including 4'b0000: pc_plus4.
- Alignment check, applied at issue:
  - If next_pc[1:0] != 2'b00 (reachable only through jump register): pc is not updated, misaligned_err <= 1, go to S_HALT.
- Throughput and latency:
  - Zero-wait-state memory: ack in the request cycle N gives instr_valid at N+1, issue at N+1, next request at N+2. This is 2 cycles per instruction.
  - Each cycle of ack delay adds 1 cycle.
- Boundary conditions:
  - imem_ack outside S_FETCH is ignored.
  - An ack arriving after a mid-fetch reset is ignored.
  - A reset mid-fetch drops imem_req in the same cycle, asynchronously.
  - pc_control and jr_target changes are ignored except at the issue edge.

Test Plan:
1. RESET_VECTOR=0, ack in the request cycle, memory holds NOPs -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle; pc=0x8 after the third fetch.
2. Ack delayed 3 cycles -> imem_req and imem_addr=0x4 stable for 4 cycles; instr_valid rises on the cycle after ack.
3. pc=0x1000_0000, instruction=0x0800_0100, pc_control=0001 -> next imem_addr=0x1000_0400.
4. Branch cases:
   - pc=0x100, imm=0xFFFF, pc_control=0011 -> next addr 0x100.
   - imm=0x0003 -> next addr 0x110.
   - pc_control=0000 -> next addr 0x104.
5. pc_control=0010, jr_target=0x0000_0202 -> misaligned_err=1, imem_req=0, pc unchanged, held for 10 cycles. Pulsing rst low clears it and fetch restarts at RESET_VECTOR.
6. Stall and mid-fetch reset:
   - stall=1 for 4 cycles in S_ISSUE while pc_control toggles -> pc, instruction and instr_valid unchanged, no request; release -> exactly one PC update.
   - rst low mid-fetch -> imem_req=0 immediately, instr_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch and program-counter unit.
// One fetch in flight; next PC chosen by control_unit at issue.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [3:0]  pc_control,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] br_offset;
    logic [31:0] jump_target;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign br_offset   = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign jump_target = {pc_plus4[31:28], instruction[25:0], 2'b00};

    // Next-PC select, driven by control_unit's decode of the held instruction
    always_comb begin
        next_pc = pc_plus4;
        case (pc_control)
            4'b0001: next_pc = jump_target;
            4'b0010: next_pc = jr_target;
            4'b0011: next_pc = pc_plus4 + br_offset;
            default: next_pc = pc_plus4;
        endcase
    end

    // Fetch/issue sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_BOOT;
            pc             <= RESET_VECTOR;
            instruction    <= 32'h0000_0000;
            instr_valid    <= 1'b0;
            imem_req       <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            misaligned_err <= 1'b1;
                            state          <= S_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    imem_req       <= 1'b0;
                    instr_valid    <= 1'b0;
                    misaligned_err <= 1'b1;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  pc_control = 4'd0;
    logic [31:0] jr_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned_err;

    int passed = 0;
    int total = 0;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .pc_control(pc_control),
        .jr_target(jr_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference next-PC rule, in plain arithmetic
    function automatic logic [31:0] model_next(
        input logic [31:0] p, input logic [31:0] ins,
        input logic [3:0] sel, input logic [31:0] jr);
        logic [31:0] seq;
        int off;
        seq = p + 32'd4;
        off = $signed(ins[15:0]) * 4;
        if (sel == 4'd1)
            return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (sel == 4'd2)
            return jr;
        if (sel == 4'd3)
            return seq + 32'(off);
        return seq;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits for a request (bounded), then acks after 'delay' cycles
    task automatic fetch(input logic [31:0] data, input int delay,
                         output logic [31:0] addr, output int waited,
                         output bit to);
        waited = 0;
        to = 1'b0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!imem_req) begin
            to = 1'b1;
            addr = 32'hDEAD_DEAD;
            return;
        end
        addr = imem_addr;
        repeat (delay) @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] jr);
        pc_control = sel;
        jr_target = jr;
        stall = 1'b0;
        @(negedge clk);
        pc_control = 4'($urandom);
        jr_target = $urandom;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        total++;
        if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
        else passed++;
        total++;
        if (instruction !== 32'h0)
            $display("FAIL reset_instr got=%h exp=%h", instruction, 32'h0);
        else passed++;
        total++;
        if ({imem_req, instr_valid, misaligned_err} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000",
                     {imem_req, instr_valid, misaligned_err});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1) $display("FAIL boot_req got=%b exp=1", imem_req);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        int w;
        bit to;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0, 0, a, w, to);
            total++;
            if (to || a !== 32'(i * 4))
                $display("FAIL seq_addr%0d got=%h exp=%h", i, a, 32'(i * 4));
            else passed++;
            if (i > 0) begin
                total++;
                if (w !== 0) $display("FAIL seq_gap%0d got=%0d exp=0", i, w);
                else passed++;
            end
            total++;
            if (instr_valid !== 1'b1)
                $display("FAIL seq_valid%0d got=%b exp=1", i, instr_valid);
            else passed++;
            if (i == 2) begin
                total++;
                if (pc !== 32'h8) $display("FAIL seq_pc got=%h exp=%h", pc, 32'h8);
                else passed++;
            end
            issue(4'd0, 32'h0);
            total++;
            if ({instr_valid, imem_req} !== 2'b01)
                $display("FAIL seq_issue%0d got=%b exp=01", i, {instr_valid, imem_req});
            else passed++;
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] a;
        int w;
        bit to;
        do_reset();
        fetch(32'h0, 0, a, w, to);
        issue(4'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({imem_req, instr_valid} !== 2'b10 || imem_addr !== 32'h4)
                $display("FAIL delay_hold%0d got=%b/%h exp=10/%h",
                         i, {imem_req, instr_valid}, imem_addr, 32'h4);
            else passed++;
            if (i == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hCAFE_0001;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        stall = 1'b1;
        total++;
        if (instr_valid !== 1'b1 || instruction !== 32'hCAFE_0001)
            $display("FAIL delay_valid got=%b/%h exp=1/%h",
                     instr_valid, instruction, 32'hCAFE_0001);
        else passed++;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (instruction !== 32'hCAFE_0001)
            $display("FAIL issue_ack_ignored got=%h exp=%h", instruction, 32'hCAFE_0001);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_jump();
        logic [31:0] a;
        int w;
        bit to;
        fetch(32'h0, 0, a, w, to);
        issue(4'd2, 32'h1000_0000);
        fetch(32'h0800_0100, 0, a, w, to);
        total++;
        if (a !== 32'h1000_0000) $display("FAIL jr_addr got=%h exp=%h", a, 32'h1000_0000);
        else passed++;
        issue(4'd1, 32'h0);
        fetch(32'h0, 1, a, w, to);
        total++;
        if (a !== 32'h1000_0400) $display("FAIL jump_addr got=%h exp=%h", a, 32'h1000_0400);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_branch();
        logic [31:0] a;
        int w;
        bit to;
        fetch(32'h0, 0, a, w, to);
        issue(4'd2, 32'h100);
        fetch(32'h1000_FFFF, 0, a, w, to);
        issue(4'd3, 32'h0);
        fetch(32'h0, 0, a, w, to);
        total++;
        if (a !== 32'h100) $display("FAIL br_back got=%h exp=%h", a, 32'h100);
        else passed++;
        issue(4'd0, 32'h0);
        fetch(32'h0, 0, a, w, to);
        total++;
        if (a !== 32'h104) $display("FAIL br_none got=%h exp=%h", a, 32'h104);
        else passed++;
        issue(4'd2, 32'h100);
        fetch(32'h1000_0003, 0, a, w, to);
        issue(4'd3, 32'h0);
        fetch(32'h0, 0, a, w, to);
        total++;
        if (a !== 32'h110) $display("FAIL br_fwd got=%h exp=%h", a, 32'h110);
        else passed++;
        issue(4'd2, 32'hFFFF_FFFC);
        fetch(32'h0, 0, a, w, to);
        issue(4'd0, 32'h0);
        fetch(32'h0, 0, a, w, to);
        total++;
        if (a !== 32'h0) $display("FAIL pc_wrap got=%h exp=%h", a, 32'h0);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        logic [31:0] p0;
        int w;
        bit to;
        fetch(32'h0, 0, a, w, to);
        p0 = pc;
        issue(4'd2, 32'h0000_0202);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({misaligned_err, imem_req, instr_valid} !== 3'b100 || pc !== p0)
                $display("FAIL halt%0d got=%b/%h exp=100/%h",
                         i, {misaligned_err, imem_req, instr_valid}, pc, p0);
            else passed++;
            imem_ack = i[0];
            @(negedge clk);
        end
        imem_ack = 1'b0;
        do_reset();
        total++;
        if (misaligned_err !== 1'b0)
            $display("FAIL halt_clear got=%b exp=0", misaligned_err);
        else passed++;
        fetch(32'h0, 0, a, w, to);
        total++;
        if (to || a !== 32'h0) $display("FAIL halt_restart got=%h exp=%h", a, 32'h0);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] p0;
        logic [31:0] i0;
        int w;
        bit to;
        fetch(32'h00AB_0010, 0, a, w, to);
        stall = 1'b1;
        p0 = pc;
        i0 = instruction;
        for (int i = 0; i < 4; i++) begin
            pc_control = 4'($urandom);
            jr_target = $urandom;
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            @(negedge clk);
            imem_ack = 1'b0;
            total++;
            if (pc !== p0 || instruction !== i0 || {instr_valid, imem_req} !== 2'b10)
                $display("FAIL stall%0d got=%h/%h/%b exp=%h/%h/10",
                         i, pc, instruction, {instr_valid, imem_req}, p0, i0);
            else passed++;
        end
        issue(4'd0, 32'h0);
        total++;
        if (pc !== p0 + 32'd4 || imem_req !== 1'b1)
            $display("FAIL stall_release got=%h/%b exp=%h/1", pc, imem_req, p0 + 32'd4);
        else passed++;
        fetch(32'h0, 2, a, w, to);
        total++;
        if (pc !== p0 + 32'd4) $display("FAIL stall_once got=%h exp=%h", pc, p0 + 32'd4);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_midfetch_reset();
        logic [31:0] a;
        int w;
        bit to;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({imem_req, instr_valid} !== 2'b00 || pc !== 32'h0)
            $display("FAIL midreset got=%b/%h exp=00/%h", {imem_req, instr_valid}, pc, 32'h0);
        else passed++;
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0)
            $display("FAIL late_ack got=%b/%h exp=0/%h", instr_valid, instruction, 32'h0);
        else passed++;
        fetch(32'h0, 0, a, w, to);
        total++;
        if (to || a !== 32'h0) $display("FAIL midreset_restart got=%h exp=%h", a, 32'h0);
        else passed++;
        issue(4'd0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] mpc;
        logic [31:0] data;
        logic [31:0] jr;
        logic [3:0]  sel;
        int w;
        int r;
        bit to;
        do_reset();
        mpc = 32'h0;
        for (int it = 0; it < 60; it++) begin
            data = $urandom;
            fetch(data, $urandom_range(0, 2), a, w, to);
            total++;
            if (to || a !== mpc) $display("FAIL rnd_addr%0d got=%h exp=%h", it, a, mpc);
            else passed++;
            total++;
            if (instruction !== data || pc !== mpc)
                $display("FAIL rnd_state%0d got=%h/%h exp=%h/%h",
                         it, instruction, pc, data, mpc);
            else passed++;
            r = $urandom_range(0, 2);
            if (r > 0) begin
                stall = 1'b1;
                repeat (r) begin
                    pc_control = 4'($urandom);
                    jr_target = $urandom;
                    @(negedge clk);
                end
            end
            r = $urandom_range(0, 7);
            sel = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
            jr = $urandom & 32'hFFFF_FFFC;
            mpc = model_next(mpc, data, sel, jr);
            issue(sel, jr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_jump();
        test_branch();
        test_misaligned();
        test_stall();
        test_midfetch_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
